// File: rtl/conv_result_reader.sv
// Starts the convolution engine, snapshots its packed result frame, then streams the
// frame out one pixel per valid/ready transfer, pixel 0 first, with last/done markers.
module conv_result_reader #(
    parameter int result_width  = 3,
    parameter int result_height = 3,
    parameter int bitwidth      = 7,
    parameter int timeout       = 64
) (
    input  logic                                            clk_en,
    input  logic                                            rst_n,
    input  logic                                            start,
    output logic                                            conv_en,
    input  logic                                            conv_fin,
    input  logic [result_width*result_height*bitwidth-1:0]  result,
    output logic [bitwidth-1:0]                             pix_data,
    output logic                                            pix_valid,
    input  logic                                            pix_ready,
    output logic                                            pix_last,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            timeout_err
);
    localparam int N  = result_width * result_height;
    localparam int FW = N * bitwidth;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(timeout);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [TW-1:0] T_LAST = TW'(timeout - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]          r_state;
    logic [FW-1:0]       r_shadow;
    logic [KW-1:0]       r_k;
    logic [TW-1:0]       r_timer;
    logic                r_conv_en;
    logic                r_pix_valid;
    logic                r_pix_last;
    logic                r_done;
    logic                r_timeout_err;
    logic [bitwidth-1:0] r_pix_data;

    logic [bitwidth-1:0] w_pix [N];
    logic [bitwidth-1:0] w_first_pix;
    logic [KW-1:0]       w_k_inc;
    logic                w_xfer;

    // Pixel 0 sits in the most significant slot of the packed frame.
    for (genvar gi = 0; gi < N; gi++) begin : g_pix
        assign w_pix[gi] = r_shadow[(N-gi)*bitwidth-1 -: bitwidth];
    end

    assign w_first_pix = result[FW-1 -: bitwidth];
    assign w_k_inc     = r_k + 1'b1;
    assign w_xfer      = r_pix_valid & pix_ready;

    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_shadow      <= '0;
            r_k           <= '0;
            r_timer       <= '0;
            r_conv_en     <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_pix_last    <= 1'b0;
            r_pix_data    <= '0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state       <= S_RUN;
                        r_conv_en     <= 1'b1;
                        r_timer       <= '0;
                        r_timeout_err <= 1'b0;
                    end
                end
                S_RUN: begin
                    // A result arriving on the expiry cycle still counts as success.
                    if (conv_fin) begin
                        r_state     <= S_STREAM;
                        r_shadow    <= result;
                        r_k         <= '0;
                        r_conv_en   <= 1'b0;
                        r_pix_valid <= 1'b1;
                        r_pix_data  <= w_first_pix;
                        r_pix_last  <= (N == 1);
                    end else if (r_timer == T_LAST) begin
                        r_state       <= S_IDLE;
                        r_conv_en     <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        if (r_k == K_LAST) begin
                            r_state     <= S_IDLE;
                            r_k         <= '0;
                            r_pix_valid <= 1'b0;
                            r_pix_last  <= 1'b0;
                            r_pix_data  <= '0;
                            r_done      <= 1'b1;
                        end else begin
                            r_k        <= w_k_inc;
                            r_pix_data <= w_pix[w_k_inc];
                            r_pix_last <= (w_k_inc == K_LAST);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign conv_en     = r_conv_en;
    assign pix_data    = r_pix_data;
    assign pix_valid   = r_pix_valid;
    assign pix_last    = r_pix_last;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_conv_result_reader.sv
// Bench for conv_result_reader: frames are modelled as lists of pixels sliced
// arithmetically from the packed result word and compared transfer by transfer.
`timescale 1ns/1ps
module tb_conv_result_reader;
    localparam int RW = 3;
    localparam int RH = 3;
    localparam int BW = 7;
    localparam int TO = 16;
    localparam int N  = RW * RH;
    localparam int FW = N * BW;

    logic          clk_en    = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          conv_fin  = 1'b0;
    logic          pix_ready = 1'b0;
    logic [FW-1:0] result    = '0;
    logic          conv_en, pix_valid, pix_last, busy, done, timeout_err;
    logic [BW-1:0] pix_data;

    int checks = 0;
    int errors = 0;

    conv_result_reader #(
        .result_width (RW),
        .result_height(RH),
        .bitwidth     (BW),
        .timeout      (TO)
    ) dut (
        .clk_en     (clk_en),
        .rst_n      (rst_n),
        .start      (start),
        .conv_en    (conv_en),
        .conv_fin   (conv_fin),
        .result     (result),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_last   (pix_last),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    always #5 clk_en = ~clk_en;

    // Reference: pixel k of a frame, pixel 0 in the top BW bits.
    function automatic logic [BW-1:0] ref_pix(input logic [FW-1:0] f, input int k);
        logic [FW-1:0] s;
        s = f >> ((N - 1 - k) * BW);
        return s[BW-1:0];
    endfunction

    function automatic logic [FW-1:0] seq_frame();
        logic [FW-1:0] f = '0;
        for (int k = 0; k < N; k++) f = (f << BW) | FW'(k + 1);
        return f;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f = '0;
        for (int k = 0; k < N; k++) f = (f << BW) | FW'($urandom_range(0, (1 << BW) - 1));
        return f;
    endfunction

    task automatic step();
        @(negedge clk_en);
    endtask

    // Launch a frame: conv_en will be seen high for 'highs' cycles before capture.
    task automatic start_frame(input logic [FW-1:0] f, input int highs);
        result = f;
        start  = 1'b1;
        step();
        start  = 1'b0;
        repeat (highs - 1) step();
        conv_fin = 1'b1;
        step();
        conv_fin = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; conv_fin = 1'b1; pix_ready = 1'b1;
        result = rand_frame();
        repeat (4) begin
            step();
            checks++;
            if ({conv_en, pix_valid, pix_last, pix_data, done, timeout_err} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got en=%0b v=%0b last=%0b data=%0d done=%0b terr=%0b, expected all 0",
                         conv_en, pix_valid, pix_last, pix_data, done, timeout_err);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy: got %0b expected 0", busy);
            end
        end
        start = 1'b0; conv_fin = 1'b0; pix_ready = 1'b0;
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || conv_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%0b en=%0b expected 0/0", busy, conv_en);
        end
    endtask

    task automatic test_normal();
        logic [FW-1:0] f;
        int cnt = 0;
        f = seq_frame();
        result = f; pix_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (conv_en === 1'b1 && busy === 1'b1) cnt++;
            if (i == 3) conv_fin = 1'b1;
            step();
        end
        conv_fin = 1'b0;
        checks++;
        if (cnt != 4 || conv_en !== 1'b0) begin
            errors++;
            $display("FAIL normal_conv_en: got high_cycles=%0d en_after=%0b expected 4/0", cnt, conv_en);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pix_valid !== 1'b1 || pix_data !== ref_pix(f, i) || pix_last !== (i == N - 1)) begin
                errors++;
                $display("FAIL normal_pixel[%0d]: got v=%0b data=%0d last=%0b expected v=1 data=%0d last=%0b",
                         i, pix_valid, pix_data, pix_last, ref_pix(f, i), (i == N - 1));
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL normal_done: got done=%0b v=%0b busy=%0b expected 1/0/0", done, pix_valid, busy);
        end
        pix_ready = 1'b0;
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL normal_done_width: got done=%0b expected 0", done);
        end
        $display("normal frame: %0d pixels, conv_en high %0d cycles", N, cnt);
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] f;
        logic [BW-1:0] held = '0;
        bit stalled = 1'b0;
        int t = 0;
        int cyc = 0;
        f = seq_frame();
        start_frame(f, 2);
        while (t < N && cyc < 60) begin
            checks++;
            if (pix_valid !== 1'b1 || pix_data !== ref_pix(f, t) || pix_last !== (t == N - 1)) begin
                errors++;
                $display("FAIL backpressure_pixel[%0d]: got v=%0b data=%0d last=%0b expected v=1 data=%0d last=%0b",
                         t, pix_valid, pix_data, pix_last, ref_pix(f, t), (t == N - 1));
            end
            if (stalled) begin
                checks++;
                if (pix_data !== held) begin
                    errors++;
                    $display("FAIL backpressure_hold: got data=%0d expected %0d", pix_data, held);
                end
            end
            pix_ready = (cyc % 2 == 0);
            stalled   = !pix_ready;
            held      = pix_data;
            if (pix_ready) t++;
            cyc++;
            step();
        end
        pix_ready = 1'b0;
        checks++;
        if (t != N || done !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_done: got transfers=%0d done=%0b v=%0b busy=%0b expected %0d/1/0/0",
                     t, done, pix_valid, busy, N);
        end
        step();
        $display("backpressure frame: %0d transfers in %0d cycles", t, cyc);
    endtask

    task automatic test_timeout();
        int cnt = 0;
        bit saw_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (conv_en === 1'b1 && cnt < 40) begin
            cnt++;
            if (pix_valid === 1'b1) saw_valid = 1'b1;
            step();
        end
        checks++;
        if (cnt != TO || timeout_err !== 1'b1 || busy !== 1'b0 || saw_valid || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_expiry: got run_cycles=%0d terr=%0b busy=%0b valid_seen=%0b expected %0d/1/0/0",
                     cnt, timeout_err, busy, saw_valid, TO);
        end
        repeat (3) step();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got terr=%0b expected 1", timeout_err);
        end
        result = rand_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1 || conv_en !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clear: got terr=%0b busy=%0b en=%0b expected 0/1/1", timeout_err, busy, conv_en);
        end
        conv_fin = 1'b1;
        step();
        conv_fin = 1'b0;
        pix_ready = 1'b1;
        repeat (N) step();
        pix_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL timeout_recover_done: got done=%0b expected 1", done);
        end
        step();
        $display("timeout: conv_en high %0d cycles", cnt);
    endtask

    task automatic test_fin_at_expiry();
        logic [FW-1:0] f;
        f = rand_frame();
        start_frame(f, TO);
        checks++;
        if (pix_valid !== 1'b1 || timeout_err !== 1'b0 || pix_data !== ref_pix(f, 0)) begin
            errors++;
            $display("FAIL fin_at_expiry: got v=%0b terr=%0b data=%0d expected 1/0/%0d",
                     pix_valid, timeout_err, pix_data, ref_pix(f, 0));
        end
        pix_ready = 1'b1;
        repeat (N) step();
        pix_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL fin_at_expiry_done: got done=%0b terr=%0b expected 1/0", done, timeout_err);
        end
        step();
        $display("fin at expiry: frame captured");
    endtask

    task automatic test_ignored();
        logic [FW-1:0] f;
        int t = 0;
        int cyc = 0;
        int dones = 0;
        bit saw_busy = 1'b0;
        f = seq_frame();
        start_frame(f, 3);
        result = '1;
        while (t < N && cyc < 100) begin
            checks++;
            if (pix_valid !== 1'b1 || pix_data !== ref_pix(f, t) || pix_last !== (t == N - 1)) begin
                errors++;
                $display("FAIL ignored_pixel[%0d]: got v=%0b data=%0d last=%0b expected v=1 data=%0d last=%0b",
                         t, pix_valid, pix_data, pix_last, ref_pix(f, t), (t == N - 1));
            end
            if (done === 1'b1) dones++;
            start     = 1'($urandom_range(0, 1));
            conv_fin  = 1'($urandom_range(0, 1));
            pix_ready = ($urandom_range(0, 3) != 0);
            if (pix_ready) t++;
            cyc++;
            step();
        end
        start = 1'b0; conv_fin = 1'b0; pix_ready = 1'b0;
        repeat (6) begin
            if (done === 1'b1) dones++;
            if (busy === 1'b1) saw_busy = 1'b1;
            step();
        end
        checks++;
        if (dones != 1 || saw_busy) begin
            errors++;
            $display("FAIL ignored_single_frame: got dones=%0d busy_after=%0b expected 1/0", dones, saw_busy);
        end
        $display("ignored events frame: %0d transfers in %0d cycles", t, cyc);
    endtask

    task automatic test_reset_mid_stream();
        logic [FW-1:0] f;
        logic [FW-1:0] f2;
        bit bad = 1'b0;
        f = rand_frame();
        start_frame(f, 2);
        pix_ready = 1'b1;
        repeat (4) step();
        checks++;
        if (pix_data !== ref_pix(f, 4) || pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got data=%0d v=%0b expected %0d/1", pix_data, pix_valid, ref_pix(f, 4));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || pix_data !== '0 || pix_last !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got v=%0b busy=%0b data=%0d last=%0b expected 0/0/0/0",
                     pix_valid, busy, pix_data, pix_last);
        end
        step();
        rst_n = 1'b1;
        repeat (6) begin
            if (done !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midreset_no_done: got activity after release, expected done=0 v=0 busy=0");
        end
        f2 = rand_frame();
        start_frame(f2, 1);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pix_valid !== 1'b1 || pix_data !== ref_pix(f2, i)) begin
                errors++;
                $display("FAIL midreset_fresh[%0d]: got v=%0b data=%0d expected v=1 data=%0d",
                         i, pix_valid, pix_data, ref_pix(f2, i));
            end
            step();
        end
        pix_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_fresh_done: got done=%0b expected 1", done);
        end
        step();
        $display("reset mid-stream: fresh frame of %0d pixels", N);
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] f1;
        logic [FW-1:0] f2;
        f1 = rand_frame();
        f2 = rand_frame();
        start_frame(f1, 1);
        pix_ready = 1'b1;
        repeat (N) step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done: got done=%0b expected 1", done);
        end
        result = f2;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || conv_en !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start_in_done: got busy=%0b en=%0b expected 1/1", busy, conv_en);
        end
        conv_fin = 1'b1;
        step();
        conv_fin = 1'b0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pix_valid !== 1'b1 || pix_data !== ref_pix(f2, i) || pix_last !== (i == N - 1)) begin
                errors++;
                $display("FAIL b2b_pixel[%0d]: got v=%0b data=%0d last=%0b expected v=1 data=%0d last=%0b",
                         i, pix_valid, pix_data, pix_last, ref_pix(f2, i), (i == N - 1));
            end
            step();
        end
        pix_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_done: got done=%0b expected 1", done);
        end
        step();
        $display("back-to-back: two frames");
    endtask

    task automatic test_random();
        logic [FW-1:0] f;
        for (int fr = 0; fr < 20; fr++) begin
            int t = 0;
            int cyc = 0;
            int highs;
            f = rand_frame();
            highs = $urandom_range(1, TO);
            start_frame(f, highs);
            checks++;
            if (conv_en !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL random_capture[%0d]: got en=%0b busy=%0b terr=%0b expected 0/1/0",
                         fr, conv_en, busy, timeout_err);
            end
            while (t < N && cyc < 200) begin
                checks++;
                if (pix_valid !== 1'b1 || pix_data !== ref_pix(f, t) || pix_last !== (t == N - 1)) begin
                    errors++;
                    $display("FAIL random_pixel[%0d][%0d]: got v=%0b data=%0d last=%0b expected v=1 data=%0d last=%0b",
                             fr, t, pix_valid, pix_data, pix_last, ref_pix(f, t), (t == N - 1));
                end
                pix_ready = ($urandom_range(0, 9) < 7);
                if (pix_ready) t++;
                cyc++;
                step();
            end
            pix_ready = 1'b0;
            checks++;
            if (t != N || done !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL random_done[%0d]: got transfers=%0d done=%0b busy=%0b expected %0d/1/0",
                         fr, t, done, busy, N);
            end
            $display("random frame %0d: fin after %0d cycles, %0d transfers in %0d cycles", fr, highs, t, cyc);
            repeat ($urandom_range(1, 3)) step();
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_backpressure();
        test_timeout();
        test_fin_at_expiry();
        test_ignored();
        test_reset_mid_stream();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
